ahb_simple_master: RTL and testbench
====================================

Name: ahb_simple_master

Overview:
- Single-master AHB-Lite initiator that turns a valid/ready command stream into pipelined single (non-burst) word transfers.
- Drives the address/control and write-data buses consumed by the downstream AHB slave.
- Returns one response per command: read data, error flag and a write/read tag.
- Sits between the system's command source (CPU/testbench sequencer) and the AHB slave. Slave selection is done by the external decoder; hready is the muxed slave hreadyout.

Parameters:
- HPROT_VAL, 4'b0011: constant driven on hprot (non-cacheable data access).
- TIMEOUT, 16: consecutive hready-low cycles in a data phase before the hang flag sets; minimum 2.

Ports:
- hclk  in  1  AHB clock; all logic on rising edge.
- hresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clock edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address; bits [1:0] are ignored.
- cmd_wdata  in  32  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse per completed transfer.
- rsp_write  out  1  the completed transfer was a write.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_err  out  1  slave returned ERROR.
- hang  out  1  sticky; TIMEOUT reached.
- hang_clr  in  1  synchronous clear of hang.
- haddr  out  32  address, [1:0] forced to 2'b00.
- hwrite  out  1  transfer direction.
- hsize  out  3  constant 3'b010 (word).
- hburst  out  3  constant 3'b000 (SINGLE).
- hprot  out  4  constant HPROT_VAL.
- htrans  out  2  2'b00 IDLE or 2'b10 NONSEQ only.
- hmastlock  out  1  constant 0.
- hwdata  out  32  write data for the current data phase.
- hready  in  1  transfer-complete / bus-ready.
- hresp  in  1  0 = OKAY, 1 = ERROR; valid only when hready = 1.
- hrdata  in  32  read data; sampled when hready = 1 in a read data phase.

Behaviour:
- Pipeline stages:
  - Address-phase register (aph_valid, aph_addr, aph_write, aph_wdata).
  - Data-phase register (dph_valid, dph_write, dph_wdata).
- Reset (async, hresetn = 0):
  - aph_valid = 0, dph_valid = 0, htrans = 2'b00.
  - haddr, hwrite, hwdata, rsp_* and hang = 0; counter = 0.
  - Constant outputs hold their constant values.
  - Reset mid-transfer discards all in-flight commands with no response.
- cmd_ready (combinational) = !aph_valid || hready.
- Address phase:
  - On accept, next cycle: aph_valid = 1, htrans = 2'b10, haddr = {cmd_addr[31:2], 2'b00}, hwrite = cmd_write.
  - Address and control are held unchanged while hready = 0.
  - If no command is accepted while aph advances, htrans = 2'b00 and haddr/hwrite hold their last values.
- Advance: at an edge with hready = 1:
  - the aph contents move to dph (dph_valid = aph_valid);
  - aph loads the new command, if one is accepted.
- hwdata = dph_wdata; stable for the whole data phase, including wait states.
- Completion: dph_valid && hready at an edge. In the following cycle:
  - rsp_valid = 1, rsp_write = dph_write, rsp_err = hresp;
  - rsp_rdata = hrdata for reads, 0 for writes.
- Throughput and latency:
  - Back-to-back commands give one transfer per cycle with zero wait states.
  - Accept edge to rsp_valid = 3 cycles minimum.
- Error handling:
  - An ERROR does not cancel the already-issued next address phase; that transfer completes normally.
  - No retry is attempted.
- Watchdog:
  - Counter increments each cycle with dph_valid && !hready; it clears on hready = 1 or when dph_valid = 0.
  - When count reaches TIMEOUT, hang = 1. The bus is not abandoned and the transfer still waits.
  - hang_clr clears hang; if hang_clr coincides with the set condition, set wins.
- Responses are strictly in command order. The command source must always accept rsp_valid; there is no backpressure.

Test Plan:
- Reset: hresetn = 0 mid-stream, then release → htrans = 00, rsp_valid = 0, hang = 0, cmd_ready = 1; no stale responses.
- Single write: cmd addr 0x0000_0004, data 0xDEADBEEF, accepted at edge T, hready = 1 →
  - T+1: htrans = 10, haddr = 0x4, hwrite = 1;
  - T+2: hwdata = DEADBEEF, htrans = 00;
  - T+3: rsp_valid = 1, rsp_write = 1, rsp_err = 0.
- Back-to-back reads: 0x08 then 0x0C on consecutive edges, slave returns 0x8 / 0xC →
  - address of the second read overlaps the data phase of the first;
  - two consecutive rsp_valid pulses with rdata 0x8, then 0xC.
- Wait states: hready = 0 for 3 cycles during a write data phase, with a read queued →
  - haddr/htrans of the queued read and hwdata held constant;
  - cmd_ready = 0;
  - responses delayed by exactly 3 cycles.
- Error: slave returns hresp = 1 with hready = 1 on a read of 0x40 → rsp_err = 1 for that response; the next pipelined transfer completes with rsp_err = 0.
- Timeout: hready held 0 for 16 cycles in a data phase → hang = 1 after the 16th cycle; hang_clr pulse → hang = 0; hready = 1 → transfer then completes normally.

Source files
------------

// File: rtl/ahb_simple_master.sv
// AHB-Lite single-master initiator: turns a valid/ready command stream into pipelined
// single-word NONSEQ transfers and returns one in-order response per command.
module ahb_simple_master #(
    parameter logic [3:0]  HPROT_VAL = 4'b0011,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        hclk,
    input  logic        hresetn,
    // command stream
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    // response stream
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    // watchdog
    output logic        hang,
    input  logic        hang_clr,
    // AHB-Lite master interface
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [1:0]  htrans,
    output logic        hmastlock,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic        hresp,
    input  logic [31:0] hrdata
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic        aph_valid;
    logic [31:0] aph_addr;
    logic        aph_write;
    logic [31:0] aph_wdata;

    logic        dph_valid;
    logic        dph_write;
    logic [31:0] dph_wdata;

    logic [CW-1:0] wdog_cnt;

    logic accept;
    logic complete;
    logic stall;
    logic hang_set;

    // The address slot frees up either when it is empty or when the bus advances.
    assign cmd_ready = !aph_valid || hready;
    assign accept    = cmd_valid && cmd_ready;
    assign complete  = dph_valid && hready;
    assign stall     = dph_valid && !hready;
    assign hang_set  = stall && (wdog_cnt == CW'(TIMEOUT - 1));

    // Address phase. Its registers hold while a stalled data phase blocks the bus,
    // and haddr/hwrite keep their last values when the slot goes idle.
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            aph_valid <= 1'b0;
            aph_addr  <= '0;
            aph_write <= 1'b0;
            aph_wdata <= '0;
        end else if (cmd_ready) begin
            aph_valid <= accept;
            if (accept) begin
                aph_addr  <= cmd_addr & ~32'h3;
                aph_write <= cmd_write;
                aph_wdata <= cmd_wdata;
            end
        end
    end

    // Data phase: the address phase moves here whenever the bus reports ready.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dph_valid <= 1'b0;
            dph_write <= 1'b0;
            dph_wdata <= '0;
        end else if (hready) begin
            dph_valid <= aph_valid;
            dph_write <= aph_write;
            dph_wdata <= aph_wdata;
        end
    end

    // One-cycle response pulse after each completed data phase.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= complete;
            rsp_write <= complete && dph_write;
            rsp_err   <= complete && hresp;
            rsp_rdata <= (complete && !dph_write) ? hrdata : '0;
        end
    end

    // Watchdog: counts consecutive wait states, saturating at TIMEOUT.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wdog_cnt <= '0;
        end else if (!stall) begin
            wdog_cnt <= '0;
        end else if (wdog_cnt != CW'(TIMEOUT)) begin
            wdog_cnt <= wdog_cnt + CW'(1);
        end
    end

    // Setting has priority so a clear in the same cycle cannot mask a fresh hang.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hang <= 1'b0;
        end else if (hang_set) begin
            hang <= 1'b1;
        end else if (hang_clr) begin
            hang <= 1'b0;
        end
    end

    assign haddr     = aph_addr;
    assign hwrite    = aph_write;
    assign htrans    = aph_valid ? 2'b10 : 2'b00;
    assign hwdata    = dph_wdata;
    assign hsize     = 3'b010;
    assign hburst    = 3'b000;
    assign hprot     = HPROT_VAL;
    assign hmastlock = 1'b0;

endmodule

// File: tb/tb_ahb_simple_master.sv
// Self-checking bench for ahb_simple_master: directed scenarios plus randomized traffic
// against an in-order memory reference model and a behavioural AHB slave.
module tb_ahb_simple_master;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_write, rsp_err;
    logic [31:0] rsp_rdata;
    logic        hang, hang_clr;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hwrite, hmastlock, hready, hresp;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;

    always #5 hclk = ~hclk;

    ahb_simple_master #(.HPROT_VAL(4'b0011), .TIMEOUT(16)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .hang(hang), .hang_clr(hang_clr),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .htrans(htrans), .hmastlock(hmastlock), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata)
    );

    typedef struct {
        logic        write;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } iss_t;

    localparam logic [31:0] ERR_RDATA = 32'hEEEE_EEEE;

    rsp_t        exp_q[$];        // expected responses, command order
    iss_t        iss_q[$];        // expected bus transfers, command order
    logic [31:0] ref_mem [32];    // reference memory, updated at command acceptance
    logic [31:0] slv_mem [32];    // slave memory, updated by bus transfers

    int   n_tests = 0;
    int   n_fail  = 0;
    int   stall_left = 0;
    int   consec = 0;
    bit   rand_mode = 0;
    bit   clr_next = 0;
    bit   last_accept;
    bit   s_dph_valid = 0;
    iss_t s_dph;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic init_mems();
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = 32'h1000_0000 + 32'(i);
            slv_mem[i] = 32'h1000_0000 + 32'(i);
        end
    endtask

    // Reference model: word memory with in-order semantics; address word 16 is an error region.
    task automatic model_accept(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [4:0] idx;
        logic       err;
        idx = a[6:2];
        err = (idx == 5'd16);
        iss_q.push_back('{{a[31:2], 2'b00}, w, d});
        if (w) begin
            exp_q.push_back('{1'b1, err, 32'h0});
            if (!err) ref_mem[idx] = d;
        end else begin
            exp_q.push_back('{1'b0, err, err ? ERR_RDATA : ref_mem[idx]});
        end
    endtask

    // One clock cycle: score responses, act as slave, drive a command, predict acceptance.
    task automatic step(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d);
        rsp_t       r;
        logic [4:0] idx;
        logic       err;
        @(negedge hclk);
        hang_clr = clr_next;

        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
                r = exp_q.pop_front();
                check("rsp_write", rsp_write, r.write);
                check("rsp_err", rsp_err, r.err);
                check("rsp_rdata", rsp_rdata, r.rdata);
            end
        end

        if (s_dph_valid && stall_left > 0) begin
            hready = 1'b0;
            stall_left--;
        end else if (s_dph_valid && rand_mode && consec < 4 && $urandom_range(0, 3) == 0) begin
            hready = 1'b0;
        end else begin
            hready = 1'b1;
        end
        consec = hready ? 0 : consec + 1;
        hresp  = 1'b0;
        hrdata = $urandom;

        if (hready && s_dph_valid) begin
            idx   = s_dph.addr[6:2];
            err   = (idx == 5'd16);
            hresp = err;
            if (s_dph.write) begin
                check("hwdata", hwdata, s_dph.wdata);
                if (!err) slv_mem[idx] = hwdata;
            end else begin
                hrdata = err ? ERR_RDATA : slv_mem[idx];
            end
        end

        if (hready) begin
            check("htrans_legal", (htrans == 2'b00 || htrans == 2'b10), 1'b1);
            if (htrans == 2'b10) begin
                if (iss_q.size() == 0) begin
                    check("issue_unexpected", htrans, 2'b00);
                    s_dph.wdata = '0;
                end else begin
                    s_dph = iss_q.pop_front();
                    check("haddr", haddr, s_dph.addr);
                    check("hwrite", hwrite, s_dph.write);
                end
                check("ctrl_const", {hsize, hburst, hprot, hmastlock}, {3'b010, 3'b000, 4'b0011, 1'b0});
                s_dph.addr  = haddr;
                s_dph.write = hwrite;
                s_dph_valid = 1;
            end else begin
                s_dph_valid = 0;
            end
        end

        cmd_valid = v;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        #1;
        last_accept = v && cmd_ready;
        if (last_accept) model_accept(w, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0);
    endtask

    // Asynchronous reset from the current point; in-flight commands are dropped.
    task automatic do_reset(input string tag);
        hresetn   = 1'b0;
        cmd_valid = 1'b0;
        hang_clr  = 1'b0;
        clr_next  = 0;
        hready    = 1'b1;
        hresp     = 1'b0;
        #2;
        check({tag, "_htrans"}, htrans, 2'b00);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_hang"}, hang, 1'b0);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        check({tag, "_haddr"}, haddr, 32'h0);
        check({tag, "_hwdata"}, hwdata, 32'h0);
        exp_q.delete();
        iss_q.delete();
        s_dph_valid = 0;
        stall_left  = 0;
        consec      = 0;
        init_mems();
        @(negedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit          pending;
        bit          w;
        logic [31:0] a, d, rnd;
        logic [4:0]  idx;

        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        hang_clr = 0; hready = 1; hresp = 0; hrdata = 0;
        #3;
        do_reset("rst0");
        idle(2);

        // Single write, zero wait states
        step(1, 1, 32'h0000_0004, 32'hDEAD_BEEF);
        check("sw_cmd_ready", cmd_ready, 1'b1);
        step(0, 0, 32'h0, 32'h0);
        check("sw_htrans_a", htrans, 2'b10);
        check("sw_haddr", haddr, 32'h4);
        check("sw_hwrite", hwrite, 1'b1);
        step(0, 0, 32'h0, 32'h0);
        check("sw_hwdata", hwdata, 32'hDEAD_BEEF);
        check("sw_htrans_d", htrans, 2'b00);
        check("sw_rsp_early", rsp_valid, 1'b0);
        step(0, 0, 32'h0, 32'h0);
        check("sw_rsp_valid", rsp_valid, 1'b1);
        idle(2);

        // Back-to-back reads with overlapping address/data phases
        ref_mem[2] = 32'h8; slv_mem[2] = 32'h8;
        ref_mem[3] = 32'hC; slv_mem[3] = 32'hC;
        step(1, 0, 32'h08, 32'h0);
        step(1, 0, 32'h0C, 32'h0);
        check("b2b_accept2", last_accept, 1'b1);
        check("b2b_haddr1", haddr, 32'h08);
        step(0, 0, 32'h0, 32'h0);
        check("b2b_haddr2", haddr, 32'h0C);
        check("b2b_htrans2", htrans, 2'b10);
        step(0, 0, 32'h0, 32'h0);
        check("b2b_rsp1", rsp_valid, 1'b1);
        check("b2b_rdata1", rsp_rdata, 32'h8);
        step(0, 0, 32'h0, 32'h0);
        check("b2b_rsp2", rsp_valid, 1'b1);
        check("b2b_rdata2", rsp_rdata, 32'hC);
        step(0, 0, 32'h0, 32'h0);
        check("b2b_rsp_end", rsp_valid, 1'b0);

        // Three wait states in a write data phase with a read queued behind it
        step(1, 1, 32'h10, 32'h1234_5678);
        step(1, 0, 32'h14, 32'h0);
        stall_left = 3;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 32'h18, 32'h0);
            check("ws_cmd_ready", cmd_ready, 1'b0);
            check("ws_htrans", htrans, 2'b10);
            check("ws_haddr", haddr, 32'h14);
            check("ws_hwdata", hwdata, 32'h1234_5678);
            check("ws_rsp_held", rsp_valid, 1'b0);
        end
        step(0, 0, 32'h0, 32'h0);
        check("ws_rsp_still_held", rsp_valid, 1'b0);
        step(0, 0, 32'h0, 32'h0);
        check("ws_rsp_w", rsp_valid, 1'b1);
        check("ws_rsp_w_write", rsp_write, 1'b1);
        step(0, 0, 32'h0, 32'h0);
        check("ws_rsp_r", rsp_valid, 1'b1);
        check("ws_rsp_r_write", rsp_write, 1'b0);
        idle(2);

        // ERROR on a read of 0x40; the pipelined next read completes normally
        step(1, 0, 32'h40, 32'h0);
        step(1, 0, 32'h44, 32'h0);
        step(0, 0, 32'h0, 32'h0);
        step(0, 0, 32'h0, 32'h0);
        check("err_rsp_valid", rsp_valid, 1'b1);
        check("err_rsp_err", rsp_err, 1'b1);
        step(0, 0, 32'h0, 32'h0);
        check("err_next_valid", rsp_valid, 1'b1);
        check("err_next_err", rsp_err, 1'b0);
        idle(2);

        // Watchdog: hang sets after 16 wait states, set beats a coincident clear
        step(1, 1, 32'h20, 32'hCAFE_F00D);
        step(0, 0, 32'h0, 32'h0);
        stall_left = 17;
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) clr_next = 1;
            step(0, 0, 32'h0, 32'h0);
            check("to_hang_pre", hang, 1'b0);
        end
        step(0, 0, 32'h0, 32'h0);
        check("to_hang_set", hang, 1'b1);
        check("to_hwdata_held", hwdata, 32'hCAFE_F00D);
        clr_next = 0;
        step(0, 0, 32'h0, 32'h0);
        check("to_hang_clr", hang, 1'b0);
        step(0, 0, 32'h0, 32'h0);
        check("to_rsp_valid", rsp_valid, 1'b1);
        check("to_rsp_err", rsp_err, 1'b0);
        idle(2);

        // Reset mid-stream: no stale responses afterwards
        rand_mode = 1;
        for (int i = 0; i < 6; i++) step(1, i[0], 32'h100 + 32'(i * 4), $urandom);
        do_reset("rst1");
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 32'h0, 32'h0);
            check("rst1_no_stale", rsp_valid, 1'b0);
        end

        // Randomized traffic with random wait states
        pending = 0;
        w = 0; a = 0; d = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!pending && $urandom_range(0, 3) != 0) begin
                pending = 1;
                rnd = $urandom;
                idx = 5'($urandom_range(0, 31));
                w   = 1'($urandom_range(0, 1));
                a   = {rnd[31:7], idx, rnd[1:0]};
                d   = $urandom;
            end
            step(pending, w, a, d);
            if (last_accept) pending = 0;
        end
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) step(0, 0, 32'h0, 32'h0);
        check("drain_rsp", exp_q.size(), 0);
        check("drain_issue", iss_q.size(), 0);
        check("rand_no_hang", hang, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
